imm_gen_stage: RTL

Parametrised, pipelined immediate and branch-target generator for the SimpleRISC decode stage. Each accepted instruction/PC pair produces a sign-, zero- or high-shifted immediate and a PC-relative branch target, stored in a 2-entry elastic buffer. Valid/ready handshakes on both sides and a flush input let the hazard unit stall or squash decode without losing or duplicating operands.

---
 rtl/imm_gen_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate and branch-target generator feeding a 2-entry elastic buffer.
// Operands are computed at accept time; the head entry is always presented on out_*.
module imm_gen_stage #(
   parameter int XLEN     = 32,
   parameter int IMM_W    = 16,
   parameter int OFF_W    = 27,
   parameter int BR_SHIFT = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_immx,
   output logic [XLEN-1:0] out_branch_target,
   output logic            out_misalign
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] immx;
      logic [XLEN-1:0] target;
      logic            misalign;
   } entry_t;

   logic [1:0]       count;
   entry_t           head_q;
   entry_t           tail_q;
   entry_t           new_e;
   logic             push;
   logic             pop;
   logic [IMM_W-1:0] imm_field;
   logic [1:0]       imm_mode;
   logic [XLEN-1:0]  immx;
   logic [XLEN-1:0]  off_sext;
   logic [XLEN-1:0]  target;
   logic             unused_instr;

   // Upper instruction bits may lie outside both fields for some parameter sets.
   assign unused_instr = ^in_instr;

   assign imm_field = in_instr[IMM_W-1:0];
   assign imm_mode  = in_instr[IMM_W+1:IMM_W];
   assign off_sext  = XLEN'(signed'(in_instr[OFF_W-1:0]));
   assign target    = in_pc + (off_sext << BR_SHIFT);

   always_comb begin
      immx = XLEN'(signed'(imm_field));
      case (imm_mode)
         2'b01:   immx = XLEN'(imm_field);
         2'b10:   immx = XLEN'(imm_field) << IMM_W;
         default: immx = XLEN'(signed'(imm_field));
      endcase
   end

   always_comb begin
      new_e          = '0;
      new_e.pc       = in_pc;
      new_e.immx     = immx;
      new_e.target   = target;
      new_e.misalign = |target[1:0];
   end

   // Handshake flags come only from the registered occupancy.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head_q <= new_e;
               else               tail_q <= new_e;
               count <= count + 2'd1;
            end
            2'b01: begin
               // With a single entry the head is left alone so idle outputs hold.
               if (count == 2'd2) head_q <= tail_q;
               count <= count - 2'd1;
            end
            2'b11: head_q <= new_e;
            default: ;
         endcase
      end
   end

   assign out_pc            = head_q.pc;
   assign out_immx          = head_q.immx;
   assign out_branch_target = head_q.target;
   assign out_misalign      = head_q.misalign;

endmodule
